wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: A (ALU/R-type result) and B (load result from data memory).
- Arbitrates round-robin and registers the winning 5-bit destination and its data onto the write port.
- Owns the destination/data select, and so replaces a free-running select on the 5-bit destination mux.
- Sits between the writeback stage and the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register destination address.
- CNT_W, 8, width of the saturating conflict counter.
- ZERO_DROP, 1, when 1, writes to register 0 are accepted but never asserted on rf_we.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  pipeline hold; no grants while high.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  A destination register.
- a_data  input  DATA_W  A write data.
- a_ready  output  1  A granted this cycle.
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  B destination register.
- b_data  input  DATA_W  B write data.
- b_ready  output  1  B granted this cycle.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  ADDR_W  register-file write address (registered).
- rf_wdata  output  DATA_W  register-file write data (registered).
- sel_a  output  1  registered select: 1 = last accepted write came from A, 0 = from B.
- conflict_cnt  output  CNT_W  saturating count of contended cycles.

Behaviour:
- Reset is synchronous and active-high: clk plus reset; no asynchronous paths.
- On reset, all of the following are 0: rf_we, rf_waddr, rf_wdata, sel_a, conflict_cnt.
- On reset, the priority pointer pri goes to PRI_A.
- a_ready and b_ready are combinational; their reset-cycle value follows the equations below with pri = PRI_A.
- Priority FSM has two states: PRI_A and PRI_B.
- Grant equations (combinational):
  - a_ready = ~stall & a_valid & (~b_valid | pri==PRI_A)
  - b_ready = ~stall & b_valid & (~a_valid | pri==PRI_B)
  - At most one of the two is high in any cycle.
- A handshake occurs when valid & ready. A requester holds valid, addr and data stable until its handshake.
- Pointer update on a handshake:
  - Grant to A -> pri = PRI_B.
  - Grant to B -> pri = PRI_A.
  - This applies even when the grantee was the only requester.
- With no handshake, pri holds. stall freezes pri.
- Write-port latency is 1 cycle. In the cycle after a handshake:
  - rf_waddr and rf_wdata take the granted addr/data.
  - sel_a = granted==A.
  - rf_we = 1, unless ZERO_DROP=1 and addr==0, in which case rf_we=0 (address and data still update).
- With no handshake: rf_we=0, while rf_waddr, rf_wdata and sel_a hold their previous values.
- conflict_cnt increments by 1 on each cycle with a_valid & b_valid & ~stall. It saturates at 2^CNT_W-1 and never wraps. Only reset clears it.
- Back-to-back: with both requesters continuously valid, grants alternate A,B,A,B… one per cycle; neither waits more than 1 cycle.
- Reset asserted mid-operation: next edge clears all registers. Any handshake in the reset cycle is discarded and produces no rf_we the following cycle.
- stall asserted: ready outputs drop the same cycle. rf_we is 0 in the following cycle, while address, data and sel_a hold.
- Requester deasserting valid without a handshake is illegal; behaviour is unspecified and not checked.

Test Plan:
- Reset then idle: hold reset 2 cycles, release with both valid=0 -> rf_we=0, rf_waddr=0, rf_wdata=0, sel_a=0, conflict_cnt=0 for 5 cycles.
- Single requester: a_valid=1, a_addr=5'd8, a_data=32'hDEADBEEF for 1 cycle -> a_ready=1 that cycle; next cycle rf_we=1, rf_waddr=8, rf_wdata=DEADBEEF, sel_a=1; pri=PRI_B.
- Contention round-robin: from reset, both valid continuously with A=(3,32'h11), B=(9,32'h22) for 4 cycles -> grant order A,B,A,B; rf_waddr sequence 3,9,3,9; sel_a 1,0,1,0; conflict_cnt=4.
- Zero-register drop: b_valid=1, b_addr=0, b_data=32'h55 with ZERO_DROP=1 -> b_ready=1; next cycle rf_we=0, rf_waddr=0, rf_wdata=32'h55, sel_a=0.
- Stall: both valid, stall=1 for 3 cycles, then 0 -> no readies and rf_we=0 during the stall; conflict_cnt unchanged; first grant after stall goes to the requester pri held before the stall.
- Saturation and mid-op reset: with CNT_W=2, hold both valid for 6 cycles -> conflict_cnt stops at 3. Then assert reset while a_ready=1 -> next cycle rf_we=0, conflict_cnt=0, pri=PRI_A.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// result (A) and the load result (B); the winning write is registered onto the port.
module wb_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 8,
    parameter bit ZERO_DROP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              sel_a,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic              pri_state
);

    // Handshake: a transfer happens on a cycle where valid & ready are both high.
    // A requester keeps valid/addr/data stable until that cycle; ready is
    // combinational from valid, stall and the priority pointer.

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t pri, pri_next;

    logic              grant_a;
    logic              grant_b;
    logic              contended;
    logic [ADDR_W-1:0] win_addr;

    assign pri_state = pri;
    assign grant_a   = a_ready;
    assign grant_b   = b_ready;
    assign contended = a_valid & b_valid & ~stall;
    assign win_addr  = grant_a ? a_addr : b_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pri <= PRI_A;
        end else begin
            pri <= pri_next;
        end
    end

    // The pointer moves past whoever was granted, even an uncontended winner.
    always_comb begin
        pri_next = pri;
        if (grant_a) begin
            pri_next = PRI_B;
        end else if (grant_b) begin
            pri_next = PRI_A;
        end
    end

    always_comb begin
        a_ready = ~stall & a_valid & (~b_valid | (pri == PRI_A));
        b_ready = ~stall & b_valid & (~a_valid | (pri == PRI_B));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            sel_a    <= 1'b0;
        end else if (grant_a || grant_b) begin
            rf_we    <= !(ZERO_DROP && (win_addr == '0));
            rf_waddr <= win_addr;
            rf_wdata <= grant_a ? a_data : b_data;
            sel_a    <= grant_a;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (contended && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a default instance plus a CNT_W=2
// instance on the same stimulus for counter saturation.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sel_a;
    logic [7:0]  conflict_cnt;
    logic        pri_state;

    logic        s_a_ready;
    logic        s_b_ready;
    logic        s_rf_we;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic        s_sel_a;
    logic [1:0]  s_conflict_cnt;
    logic        s_pri_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [36:0] exp_q[$];
    logic [36:0] exp_w;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk(clk), .reset(reset), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sel_a(sel_a), .conflict_cnt(conflict_cnt), .pri_state(pri_state)
    );

    wb_port_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(s_b_ready),
        .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
        .sel_a(s_sel_a), .conflict_cnt(s_conflict_cnt), .pri_state(s_pri_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall   = 1'b0;
        a_valid = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_we",    rf_we, 0);
            check("idle_waddr", rf_waddr, 0);
            check("idle_wdata", rf_wdata, 0);
            check("idle_sel_a", sel_a, 0);
            check("idle_cnt",   conflict_cnt, 0);
            check("idle_pri",   pri_state, 0);
        end

        // Single requester A
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'hDEADBEEF;
        #1;
        check("single_a_ready", a_ready, 1);
        check("single_b_ready", b_ready, 0);
        step();
        a_valid = 1'b0;
        check("single_we",    rf_we, 1);
        check("single_waddr", rf_waddr, 8);
        check("single_wdata", rf_wdata, 32'hDEADBEEF);
        check("single_sel_a", sel_a, 1);
        check("single_pri",   pri_state, 1);
        step();
        check("single_we_drop", rf_we, 0);
        check("single_hold",    rf_waddr, 8);

        // Contention round-robin from reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_a_ready", a_ready, (i % 2 == 0));
            check("rr_b_ready", b_ready, (i % 2 == 1));
            exp_q.push_back((i % 2 == 0) ? {5'd3, 32'h11} : {5'd9, 32'h22});
            step();
            exp_w = exp_q.pop_front();
            check("rr_we",    rf_we, 1);
            check("rr_write", {rf_waddr, rf_wdata}, exp_w);
            check("rr_sel_a", sel_a, (i % 2 == 0));
        end
        check("rr_cnt",     conflict_cnt, 4);
        check("rr_cnt_sat", s_conflict_cnt, 3);
        check("rr_pri",     pri_state, 0);
        a_valid = 1'b0; b_valid = 1'b0;

        // Zero-register drop
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h55;
        #1;
        check("zero_b_ready", b_ready, 1);
        step();
        b_valid = 1'b0;
        check("zero_we",    rf_we, 0);
        check("zero_waddr", rf_waddr, 0);
        check("zero_wdata", rf_wdata, 32'h55);
        check("zero_sel_a", sel_a, 0);
        check("zero_pri",   pri_state, 0);

        // Put pointer on B, then stall with both requesting
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h77;
        step();
        a_valid = 1'b0;
        check("pre_stall_we", rf_we, 1);
        check("pre_stall_pri", pri_state, 1);
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h22;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_a_ready", a_ready, 0);
            check("stall_b_ready", b_ready, 0);
            step();
            check("stall_we",    rf_we, 0);
            check("stall_waddr", rf_waddr, 4);
            check("stall_wdata", rf_wdata, 32'h77);
            check("stall_sel_a", sel_a, 1);
            check("stall_cnt",   conflict_cnt, 4);
            check("stall_pri",   pri_state, 1);
        end
        stall = 1'b0;
        #1;
        check("post_stall_a_ready", a_ready, 0);
        check("post_stall_b_ready", b_ready, 1);
        step();
        check("post_stall_we",    rf_we, 1);
        check("post_stall_waddr", rf_waddr, 9);
        check("post_stall_wdata", rf_wdata, 32'h22);
        check("post_stall_sel_a", sel_a, 0);
        check("post_stall_cnt",   conflict_cnt, 5);

        // Saturation with CNT_W=2, then reset while A is being granted
        for (int i = 0; i < 6; i++) begin
            step();
            check("sat_cnt", s_conflict_cnt, 3);
        end
        check("sat_cnt_wide", conflict_cnt, 11);
        #1;
        check("midrst_a_ready", a_ready, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        check("midrst_we",      rf_we, 0);
        check("midrst_waddr",   rf_waddr, 0);
        check("midrst_cnt",     conflict_cnt, 0);
        check("midrst_cnt_sat", s_conflict_cnt, 0);
        check("midrst_pri",     pri_state, 0);
        step();
        check("midrst_we_after", rf_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
